// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the FSM state encoding, the word geometry and the frame count width.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/imem_boot_loader_timeout.sv
// Inter-byte idle counter; flags expiry once TIMEOUT idle cycles have elapsed.
// A TIMEOUT of 0 disables expiry entirely.
module loader_timeout #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;

    // Count idle cycles, saturating at the expiry point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to
// instruction memory and releases the core PC only after a verified image.
module imem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [31:0]       wr_din0,
    output logic              resetpc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_index;
    logic [7:0]       r_xor;
    logic [1:0]       r_lane;
    logic [31:0]      r_word;

    logic             w_hs;
    logic             w_cnt_state;
    logic             w_tmo_clr;
    logic             w_expired;
    logic [CNT_W-1:0] w_n;
    logic [31:0]      w_word_nxt;
    logic [CNT_W+1:0] w_byte_addr;

    assign w_cnt_state = (r_state == CNT_HI) || (r_state == DATA) || (r_state == CSUM);
    assign rx_ready    = !reset && !restart && (w_cnt_state || (r_state == CNT_LO));
    assign w_hs        = rx_valid && rx_ready;
    // Leaving a counting state or entering one always passes through a handshake
    // or a non-counting state, so this also clears the counter on state entry.
    assign w_tmo_clr   = restart || w_hs || !w_cnt_state;
    assign w_n         = {rx_data, r_count[7:0]};
    assign w_word_nxt  = {rx_data, r_word[31:8]};
    assign w_byte_addr = {r_index, 2'b00};

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_tmo_clr),
        .i_en      (w_cnt_state),
        .o_expired (w_expired)
    );

    // Frame sequencer with registered write port and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= CNT_LO;
            r_count  <= '0;
            r_index  <= '0;
            r_xor    <= 8'h00;
            r_lane   <= 2'd0;
            r_word   <= 32'h0000_0000;
            we0      <= 1'b0;
            wr_addr0 <= '0;
            wr_din0  <= 32'h0000_0000;
            resetpc  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (restart) begin
            r_state <= CNT_LO;
            r_index <= '0;
            r_xor   <= 8'h00;
            r_lane  <= 2'd0;
            we0     <= 1'b0;
            resetpc <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else if (w_expired) begin
            r_state <= ERR;
            we0     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
        end else begin
            we0 <= 1'b0;
            case (r_state)
                CNT_LO: begin
                    if (w_hs) begin
                        r_count <= {8'h00, rx_data};
                        r_state <= CNT_HI;
                        busy    <= 1'b1;
                    end
                end
                CNT_HI: begin
                    if (w_hs) begin
                        r_count <= w_n;
                        if ((w_n == '0) || (w_n > CNT_W'(DEPTH_WORDS))) begin
                            r_state <= ERR;
                            busy    <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            r_index <= '0;
                            r_xor   <= 8'h00;
                            r_lane  <= 2'd0;
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        r_word <= w_word_nxt;
                        r_xor  <= r_xor ^ rx_data;
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'(BYTES_PER_WORD - 1)) begin
                            we0      <= 1'b1;
                            wr_addr0 <= ADDR_W'(w_byte_addr);
                            wr_din0  <= w_word_nxt;
                            r_state  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_index <= r_index + CNT_W'(1);
                    if ((r_index + CNT_W'(1)) == r_count) begin
                        r_state <= CSUM;
                    end else begin
                        r_state <= DATA;
                    end
                end
                CSUM: begin
                    if (w_hs) begin
                        busy <= 1'b0;
                        if (rx_data == r_xor) begin
                            r_state <= DONE;
                            resetpc <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            err     <= 1'b1;
                        end
                    end
                end
                DONE: r_state <= DONE;
                ERR:  r_state <= ERR;
                default: begin
                    r_state <= ERR;
                    busy    <= 1'b0;
                    err     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized bench for imem_boot_loader against a frame-level
// reference model (expected writes, checksum and outcome derived per frame).
module tb_imem_boot_loader;

    localparam int DEPTH = 128;
    localparam int AW    = 9;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          restart;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          we0;
    logic [AW-1:0] wr_addr0;
    logic [31:0]   wr_din0;
    logic          resetpc;
    logic          busy;
    logic          done;
    logic          err;

    int n_chk  = 0;
    int n_pass = 0;
    int mon_bad = 0;
    int cyc = 0;
    logic [AW-1:0] cap_addr[$];
    logic [31:0]   cap_data[$];

    imem_boot_loader #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (AW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .we0      (we0),
        .wr_addr0 (wr_addr0),
        .wr_din0  (wr_din0),
        .resetpc  (resetpc),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture writes and track that rx_ready is low exactly in write cycles.
    always @(negedge clk) begin
        if (!reset) begin
            if (we0) begin
                cap_addr.push_back(wr_addr0);
                cap_data.push_back(wr_din0);
            end
            if (!restart && busy && (rx_ready !== !we0)) mon_bad++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        w = 0;
        @(negedge clk);
        while (!rx_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("hs_bound", 64'(w), 64'(0));
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] n, input logic [31:0] words[$],
                             input logic csum_bad, input int maxgap, input logic do_rst);
        int base, bad0, c0;
        logic [7:0] xs;
        logic legal;
        logic [AW-1:0] ea;
        if (do_rst) do_restart();
        base = cap_addr.size();
        bad0 = mon_bad;
        c0 = cyc;
        xs = 8'h00;
        legal = (n != 16'd0) && (int'(n) <= DEPTH);
        send_byte(n[7:0], $urandom_range(0, maxgap));
        send_byte(n[15:8], $urandom_range(0, maxgap));
        if (!legal) begin
            chk("cnt_err", {63'd0, err}, 64'd1);
            chk("cnt_pc", {63'd0, resetpc}, 64'd0);
            chk("cnt_nowr", 64'(cap_addr.size() - base), 64'd0);
            return;
        end
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                xs ^= words[i][8*k +: 8];
                send_byte(words[i][8*k +: 8], $urandom_range(0, maxgap));
            end
        end
        chk("pre_done", {62'd0, done, resetpc}, 64'd0);
        send_byte(csum_bad ? (xs ^ 8'h01) : xs, $urandom_range(0, maxgap));
        chk("done", {63'd0, done}, {63'd0, !csum_bad});
        chk("resetpc", {63'd0, resetpc}, {63'd0, !csum_bad});
        chk("err", {63'd0, err}, {63'd0, csum_bad});
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("nwr", 64'(cap_addr.size() - base), 64'(n));
        foreach (words[i]) begin
            ea = AW'(i * 4);
            if (base + i < cap_addr.size()) begin
                chk("wr_addr", 64'(cap_addr[base+i]), 64'(ea));
                chk("wr_data", 64'(cap_data[base+i]), 64'(words[i]));
            end
        end
        chk("rdy_vs_write", 64'(mon_bad - bad0), 64'd0);
        if (maxgap == 0) chk("load_cycles", 64'(cyc - c0), 64'(3 + 5 * int'(n)));
    endtask

    initial begin
        logic [31:0] img[$];
        logic [31:0] wq[$];
        logic [31:0] none[$];
        int base;
        int nr;

        img = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        reset = 1'b1;
        restart = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        @(posedge clk);
        #1;
        chk("rst_outs", {we0, wr_addr0, wr_din0, resetpc, busy, done, err, rx_ready}, 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_rel_rdy", {63'd0, rx_ready}, 64'd1);

        // Three-word load, with and without backpressure, then bad checksum.
        run_frame(16'd3, img, 1'b0, 0, 1'b0);
        do_restart();
        chk("restart_pc", {62'd0, resetpc, done}, 64'd0);
        run_frame(16'd3, img, 1'b0, 6, 1'b1);
        run_frame(16'd3, img, 1'b1, 0, 1'b1);

        // Count bounds.
        run_frame(16'd0, none, 1'b0, 0, 1'b1);
        run_frame(16'd129, none, 1'b0, 0, 1'b1);
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
        run_frame(16'd128, wq, 1'b0, 0, 1'b1);

        // Randomized frames with gaps below the timeout.
        for (int r = 0; r < 8; r++) begin
            nr = $urandom_range(1, 8);
            wq.delete();
            for (int i = 0; i < nr; i++) wq.push_back($urandom);
            run_frame(16'(nr), wq, ($urandom_range(0, 3) == 0), 10, 1'b1);
        end

        // Timeout after five data bytes.
        do_restart();
        base = cap_addr.size();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        send_byte(8'h55, 0);
        repeat (TMO) begin
            @(posedge clk);
            #1;
        end
        chk("tmo_early", {63'd0, err}, 64'd0);
        @(posedge clk);
        #1;
        chk("tmo_err", {63'd0, err}, 64'd1);
        chk("tmo_pc", {63'd0, resetpc}, 64'd0);
        chk("tmo_nwr", 64'(cap_addr.size() - base), 64'd1);
        if (cap_addr.size() > base) chk("tmo_data", 64'(cap_data[base]), 64'h11223344);

        // Restart with a simultaneous byte in DATA, then full reload.
        do_restart();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rx_valid = 1'b1;
        rx_data = 8'h03;
        restart = 1'b1;
        @(negedge clk);
        chk("rst_rdy_low", {63'd0, rx_ready}, 64'd0);
        @(posedge clk);
        #1;
        restart = 1'b0;
        rx_valid = 1'b0;
        chk("rst_status", {busy, done, err, resetpc, we0}, 64'd0);
        run_frame(16'd3, img, 1'b0, 0, 1'b0);

        // Asynchronous reset during the write cycle.
        do_restart();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        chk("pre_rst_we", {63'd0, we0}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst", {we0, wr_addr0, wr_din0, resetpc, busy, done, err, rx_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame(16'd3, img, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Program loader sitting directly upstream of the pipelined core's instruction-memory write port. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word goes out on the `we0`/`wr_addr0`/`wr_din0` port at consecutive word addresses. `resetpc` is held low during loading and raised only after a length- and checksum-verified image, which replaces hand-driven bench loading of the instruction memory.

## Interface

Parameters:

- `DEPTH_WORDS`, 128, instruction-memory capacity in words.
- `ADDR_W`, 9, byte-address width of `wr_addr0`; must be ≥ clog2(4·DEPTH_WORDS).
- `TIMEOUT`, 65535, maximum idle cycles between bytes once a frame has started; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `restart`  in  1  synchronous request to abort and reload.
- `rx_valid`  in  1  byte available.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `we0`  out  1  instruction-memory write strobe.
- `wr_addr0`  out  ADDR_W  byte address; always word-aligned.
- `wr_din0`  out  32  write data.
- `resetpc`  out  1  0 holds the core PC in reset; 1 releases it.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  image verified and core released.
- `err`  out  1  frame rejected.

## Operation

Frame format, in order:

- Word count N: low byte, then high byte (16-bit).
- 4N data bytes, least-significant byte of each word first.
- One checksum byte: the XOR of all 4N data bytes.

State machine:

- **CNT_LO**: accept the low count byte, then go to CNT_HI. Waits indefinitely; no timeout applies here.
- **CNT_HI**: accept the high count byte. If N==0 or N>DEPTH_WORDS, go to ERR; otherwise clear the word index and running XOR and go to DATA.
- **DATA**: accept bytes into a 2-bit byte lane. Each byte is shifted into the word and XORed into the checksum. When lane 3 is accepted, go to WRITE.
- **WRITE**: issue one write, then increment the word index. Go to CSUM if the index now equals N, else back to DATA.
- **CSUM**: accept the checksum byte. Go to DONE on a match, ERR on a mismatch.
- **DONE**: terminal. `resetpc`=1, `done`=1.
- **ERR**: terminal. `resetpc`=0, `err`=1.

Handshake and address rules:

- A byte is consumed only when `rx_valid && rx_ready`.
- `rx_ready` = !`reset` && !`restart` && state ∈ {CNT_LO, CNT_HI, DATA, CSUM}.
- `wr_addr0` = word_index·4, truncated to ADDR_W bits; the first write is at address 0.
- Writes are not rolled back on a later checksum failure; the core simply stays held.

Timeout:

- An idle counter runs in CNT_HI, DATA and CSUM; it is cleared on every handshake and on every state entry.
- When the count reaches TIMEOUT (and TIMEOUT is nonzero), the next state is ERR.

Restart:

- `restart` in any state forces CNT_LO on the next edge.
- It clears `done`, `err`, the index, the XOR and the timeout counter.
- `resetpc` drops to 0 on that same edge.
- `restart` wins over a simultaneous byte, which is not consumed because `rx_ready` is forced low.

Reset:

- Asynchronous `reset` forces CNT_LO.
- All outputs go to 0 (`we0`, `wr_addr0`, `wr_din0`, `resetpc`, `busy`, `done`, `err`); `rx_ready` is 0 while `reset` is high.

## Timing

- All outputs except `rx_ready` are registered.
- `we0` is high for exactly one cycle, in the cycle after the lane-3 handshake. `wr_addr0` and `wr_din0` are valid in that cycle and hold their values until the next write.
- `rx_ready` is 0 for that one WRITE cycle, giving a sustained throughput of 4 bytes per 5 cycles.
- `resetpc` and `done` rise 1 cycle after the checksum handshake.
- `err` rises 1 cycle after the rejecting handshake or after the timeout is reached.
- `busy` = 1 in CNT_HI, DATA, WRITE and CSUM.
- Minimum load time for N words: 2 + 5N + 1 cycles with `rx_valid` held high.

## Structure

- Package `boot_loader_pkg` holds:
  - the state enum (CNT_LO, CNT_HI, DATA, WRITE, CSUM, DONE, ERR);
  - constant `BYTES_PER_WORD`=4;
  - the count width, 16.
- One sub-module, `loader_timeout`: an idle counter with clear/enable inputs and an expiry output, parameterised by TIMEOUT.

## Test plan

- **Three-word load.** Stream 03 00, 93 00 50 00, 13 01 A0 00, B3 81 20 00, 63. Expect writes (0, 0x00500093), (4, 0x00A00113), (8, 0x002081B3); `resetpc`=1 and `done`=1 one cycle after byte 63.
- **Bad checksum.** Same image with checksum byte 0x62. Expect the same three writes, `err`=1 and `resetpc` held at 0.
- **Count bounds.** Stream 00 00, then separately 81 00 (N=129). Expect `err`=1 after the second byte of each, with no `we0` pulse.
- **Backpressure and gaps.** Random `rx_valid` gaps shorter than TIMEOUT. Expect identical writes, with `rx_ready` low exactly in each WRITE cycle.
- **Timeout.** With TIMEOUT=16, stop the stream after 5 data bytes. Expect `err`=1 at idle cycle 17; only the first word has been written.
- **Restart and reset mid-frame.** Pulse `restart` together with a valid byte in DATA: the byte is not consumed, the state returns to CNT_LO and `resetpc`=0, and a full reload then succeeds. Assert `reset` mid-write: all outputs are 0 immediately.
